mbinit_param_resp: RTL

- Responder side of the MBINIT.PARAM exchange in the LTSM MBINIT sub-state.
- Captures the partner's configuration request carrying max data rate, clock mode, phase clock and voltage swing, and checks it for reserved encodings.
- Resolves it against the local capabilities held in the local parameter register, returns the configuration response, and exports the negotiated values to the MBINIT controller.

---
 rtl/mbinit_param_resp.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mbinit_param_resp.sv
// MBINIT.PARAM responder: captures, resolves and answers the partner request.
// Optional SEND timeout when MBINIT_PARAM_TIMEOUT_EN is defined.
module mbinit_param_resp #(
`ifdef MBINIT_PARAM_TIMEOUT_EN
    parameter int TIMEOUT_CYCLES = 8000,
`endif
    parameter int MAX_RATE_CODE = 5
) (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic       i_Enable,
    input  logic [2:0] i_Local_Max_DataRate,
    input  logic [1:0] i_Local_Clock_Mode,
    input  logic [1:0] i_Local_Phase_Clock,
    input  logic       i_Rx_Req_Valid,
    input  logic [2:0] i_Rx_Req_DataRate,
    input  logic [1:0] i_Rx_Req_Clock_Mode,
    input  logic [1:0] i_Rx_Req_Phase_Clock,
    input  logic [4:0] i_Rx_Req_Voltage_Swing,
    input  logic       i_Tx_Ack,
    output logic       o_Tx_Resp_Valid,
    output logic [2:0] o_Tx_Resp_DataRate,
    output logic [1:0] o_Tx_Resp_Clock_Mode,
    output logic [1:0] o_Tx_Resp_Phase_Clock,
    output logic [4:0] o_Remote_Voltage_Swing,
    output logic       o_Done,
    output logic       o_Error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_REQ,
        S_RESOLVE,
        S_SEND,
        S_DONE,
        S_ERROR
    } state_t;

    state_t state, state_nxt;

    logic [2:0] cap_rate;
    logic [1:0] cap_cm;
    logic [1:0] cap_pc;
    logic [4:0] cap_swing;
    logic [2:0] neg_rate;
    logic [1:0] neg_cm;
    logic [1:0] neg_pc;

    logic       capture;
    logic       commit;
    logic       resolve_err;
    logic       timeout;

    assign capture = i_Enable && (state == S_WAIT_REQ) && i_Rx_Req_Valid;
    assign commit  = i_Enable && (state == S_RESOLVE) && !resolve_err;

    // Reserved encodings and any capability mismatch fail the exchange
    always_comb begin
        resolve_err = 1'b0;
        if (int'(cap_rate) > MAX_RATE_CODE) resolve_err = 1'b1;
        if (cap_cm == 2'b11)                resolve_err = 1'b1;
        if (cap_pc == 2'b11)                resolve_err = 1'b1;
        if (cap_cm != i_Local_Clock_Mode)   resolve_err = 1'b1;
        if (cap_pc != i_Local_Phase_Clock)  resolve_err = 1'b1;
    end

`ifdef MBINIT_PARAM_TIMEOUT_EN
    logic [13:0] send_cnt;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            send_cnt <= '0;
        end else if (state == S_SEND) begin
            send_cnt <= send_cnt + 14'd1;
        end else begin
            send_cnt <= '0;
        end
    end

    assign timeout = (state == S_SEND) &&
                     (int'(send_cnt) >= TIMEOUT_CYCLES - 1);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!i_Enable) begin
            state_nxt = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:     state_nxt = S_WAIT_REQ;
                S_WAIT_REQ: if (i_Rx_Req_Valid) state_nxt = S_RESOLVE;
                S_RESOLVE:  state_nxt = resolve_err ? S_ERROR : S_SEND;
                S_SEND: begin
                    if (i_Tx_Ack)     state_nxt = S_DONE;
                    else if (timeout) state_nxt = S_ERROR;
                end
                S_DONE:     state_nxt = S_DONE;
                S_ERROR:    state_nxt = S_ERROR;
                default:    state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            cap_rate  <= '0;
            cap_cm    <= '0;
            cap_pc    <= '0;
            cap_swing <= '0;
        end else if (capture) begin
            cap_rate  <= i_Rx_Req_DataRate;
            cap_cm    <= i_Rx_Req_Clock_Mode;
            cap_pc    <= i_Rx_Req_Phase_Clock;
            cap_swing <= i_Rx_Req_Voltage_Swing;
        end
    end

    // Negotiated values only move on a successful resolve
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            neg_rate <= '0;
            neg_cm   <= '0;
            neg_pc   <= '0;
        end else if (commit) begin
            neg_rate <= (cap_rate < i_Local_Max_DataRate) ?
                        cap_rate : i_Local_Max_DataRate;
            neg_cm   <= cap_cm;
            neg_pc   <= cap_pc;
        end
    end

    assign o_Tx_Resp_Valid        = (state == S_SEND);
    assign o_Done                 = (state == S_DONE);
    assign o_Error                = (state == S_ERROR);
    assign o_Tx_Resp_DataRate     = neg_rate;
    assign o_Tx_Resp_Clock_Mode   = neg_cm;
    assign o_Tx_Resp_Phase_Clock  = neg_pc;
    assign o_Remote_Voltage_Swing = cap_swing;

endmodule
